// File: rtl/dbg_pkg.sv
// Shared definitions for the debug command parser: command and response
// byte codes, FSM state encoding and a saturating counter helper.
package dbg_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ  = 8'h72;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DHI      = 3'd2,
    ST_DLO      = 3'd3,
    ST_BUS      = 3'd4,
    ST_RESP_HI  = 3'd5,
    ST_RESP_LO  = 3'd6,
    ST_RESP_ACK = 3'd7
  } dbg_state_t;

  // True for the two bytes that open a frame.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dbg_cmd_parser.sv
// UART-side debug command parser: decodes 0x77 write / 0x72 read frames,
// performs one access on the debug register bus and returns the response
// bytes (read data or ACK/NAK) to the UART transmitter.
module dbg_cmd_parser
  import dbg_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT  = 1023,
  parameter int unsigned BYTE_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  dbg_a,
  output logic [15:0] dbg_di,
  output logic        dbg_we,
  output logic        dbg_rd,
  input  logic [15:0] dbg_do,
  input  logic        dbg_ready,
  output logic        busy,
  output logic        rx_drop
);

  localparam logic [15:0] BUS_LAST  = 16'(BUS_TIMEOUT - 1);
  localparam logic [15:0] BYTE_LAST = 16'(BYTE_TIMEOUT - 1);

  dbg_state_t  state_q, state_d;
  logic        is_wr_q;
  logic [15:0] rd_data_q;
  logic [7:0]  resp_code_q;
  logic [15:0] bus_cnt_q;
  logic [15:0] idle_cnt_q;
  logic        rx_drop_q;
  logic        byte_timeout;
  logic        bus_timeout;
  logic        drop_state;

  assign byte_timeout = (idle_cnt_q >= BYTE_LAST);
  assign bus_timeout  = (bus_cnt_q >= BUS_LAST);
  assign drop_state   = (state_q == ST_BUS)     || (state_q == ST_RESP_HI) ||
                        (state_q == ST_RESP_LO) || (state_q == ST_RESP_ACK);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: frame decoding, bus completion/timeout, tx handshake.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (rx_valid && is_cmd(rx_data)) state_d = ST_ADDR;
      ST_ADDR:
        if (rx_valid)          state_d = is_wr_q ? ST_DHI : ST_BUS;
        else if (byte_timeout) state_d = ST_IDLE;
      ST_DHI:
        if (rx_valid)          state_d = ST_DLO;
        else if (byte_timeout) state_d = ST_IDLE;
      ST_DLO:
        if (rx_valid)          state_d = ST_BUS;
        else if (byte_timeout) state_d = ST_IDLE;
      ST_BUS:
        if (dbg_ready)         state_d = is_wr_q ? ST_RESP_ACK : ST_RESP_HI;
        else if (bus_timeout)  state_d = ST_RESP_ACK;
      ST_RESP_HI:
        if (tx_ready)          state_d = ST_RESP_LO;
      ST_RESP_LO:
        if (tx_ready)          state_d = ST_IDLE;
      ST_RESP_ACK:
        if (tx_ready)          state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Datapath: frame fields, captured read data, response code and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_wr_q     <= 1'b0;
      dbg_a       <= 8'h00;
      dbg_di      <= 16'h0000;
      rd_data_q   <= 16'h0000;
      resp_code_q <= 8'h00;
      bus_cnt_q   <= 16'h0000;
      idle_cnt_q  <= 16'h0000;
      rx_drop_q   <= 1'b0;
    end else begin
      rx_drop_q <= rx_valid && drop_state;
      unique case (state_q)
        ST_IDLE: begin
          idle_cnt_q <= 16'h0000;
          bus_cnt_q  <= 16'h0000;
          if (rx_valid && is_cmd(rx_data)) is_wr_q <= (rx_data == CMD_WRITE);
        end
        ST_ADDR: begin
          if (rx_valid) begin
            dbg_a      <= rx_data;
            idle_cnt_q <= 16'h0000;
          end else begin
            idle_cnt_q <= sat_inc(idle_cnt_q);
          end
        end
        ST_DHI: begin
          if (rx_valid) begin
            dbg_di[15:8] <= rx_data;
            idle_cnt_q   <= 16'h0000;
          end else begin
            idle_cnt_q <= sat_inc(idle_cnt_q);
          end
        end
        ST_DLO: begin
          if (rx_valid) begin
            dbg_di[7:0] <= rx_data;
            idle_cnt_q  <= 16'h0000;
          end else begin
            idle_cnt_q <= sat_inc(idle_cnt_q);
          end
        end
        ST_BUS: begin
          bus_cnt_q <= sat_inc(bus_cnt_q);
          if (dbg_ready) begin
            resp_code_q <= RSP_ACK;
            if (!is_wr_q) rd_data_q <= dbg_do;
          end else if (bus_timeout) begin
            resp_code_q <= RSP_NAK;
          end
        end
        default: begin
          bus_cnt_q <= 16'h0000;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; strobes drop as BUS is left.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    dbg_we   = (state_q == ST_BUS) && is_wr_q;
    dbg_rd   = (state_q == ST_BUS) && !is_wr_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      ST_RESP_HI:  begin tx_valid = 1'b1; tx_data = rd_data_q[15:8]; end
      ST_RESP_LO:  begin tx_valid = 1'b1; tx_data = rd_data_q[7:0];  end
      ST_RESP_ACK: begin tx_valid = 1'b1; tx_data = resp_code_q;     end
      default:     begin tx_valid = 1'b0; tx_data = 8'h00;           end
    endcase
  end

  assign rx_drop = rx_drop_q;

endmodule

// File: doc/dbg_cmd_parser.md
DBG_CMD_PARSER -- requirements
Module: dbg_cmd_parser

Interface
REQ-001 Parameter BUS_TIMEOUT, default 1023: maximum cycles a bus access waits for dbg_ready, range 1..65535.
REQ-002 Parameter BYTE_TIMEOUT, default 50000: maximum idle cycles allowed between bytes of a partial frame, range 1..65535.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data; there is no backpressure.
REQ-007 tx_data  output  8  response byte to the UART transmitter.
REQ-008 tx_valid  output  1  tx_data valid; held until accepted.
REQ-009 tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready.
REQ-010 dbg_a  output  8  debug register address.
REQ-011 dbg_di  output  16  debug write data.
REQ-012 dbg_we  output  1  write strobe, held until dbg_ready.
REQ-013 dbg_rd  output  1  read strobe, held until dbg_ready.
REQ-014 dbg_do  input  16  read data, valid in the cycle dbg_ready=1.
REQ-015 dbg_ready  input  1  access complete; combinational from dbg_a/dbg_we/dbg_rd.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 rx_drop  output  1  one-cycle pulse when a byte is discarded because the block is in BUS or a RESP state.

Function
REQ-018 Frame format: write = 0x77, addr, data_hi, data_lo; read = 0x72, addr.
REQ-019 FSM states and transitions:
- IDLE: on 0x77 or 0x72 go to ADDR; any other byte is ignored silently.
- ADDR: on read, go to BUS.
- ADDR: on write, go DHI, then DLO, then BUS.
- BUS: completes the bus access, then proceeds to the response states.
- RESP_HI, RESP_LO, RESP_ACK: send the response, then return to IDLE.
REQ-020 Bus access strobes:
- In BUS, dbg_a, dbg_di and one strobe (dbg_we or dbg_rd) are driven from the first BUS cycle.
- They are held stable until the cycle dbg_ready=1 is sampled.
- The strobe is deasserted in the following cycle, so exactly one ready cycle is consumed per access.
REQ-021 Read completion: dbg_do is captured on the dbg_ready cycle, then sent as RESP_HI (dbg_do[15:8]) followed by RESP_LO (dbg_do[7:0]).
REQ-022 Write completion: after dbg_ready, RESP_ACK sends 0x06.
REQ-023 Bus timeout:
- A 16-bit counter runs in BUS.
- If it reaches BUS_TIMEOUT without dbg_ready, the strobe drops and RESP_ACK sends 0x15 (NAK) for both read and write.
REQ-024 tx handshake: tx_valid is asserted on entry to each RESP state; the state advances only on tx_valid && tx_ready; tx_valid is 0 in all other states.
REQ-025 Byte timeout:
- In ADDR, DHI or DLO, a 16-bit idle counter resets on each rx_valid.
- On reaching BYTE_TIMEOUT, the FSM returns to IDLE with no bus access and no response.
REQ-026 Dropped bytes: rx_valid in BUS or any RESP state drops the byte and pulses rx_drop; that byte never starts a frame.
REQ-027 Immediate ready: dbg_ready=1 in the first BUS cycle completes the access in that cycle, with a strobe width of 1.
REQ-028 Counters saturate and never wrap.

Reset
REQ-029 While rst_n=0 at a clock edge:
- The state becomes IDLE.
- dbg_a=0x00, dbg_di=0x0000, dbg_we=0, dbg_rd=0.
- tx_valid=0, tx_data=0x00, busy=0, rx_drop=0, and both counters are 0.
REQ-030 Reset mid-operation, including BUS with a strobe asserted, takes effect at the next edge; the partial frame is discarded and no response is sent.

Structure
REQ-031 The command bytes (0x77, 0x72), response bytes (0x06, 0x15) and the state encoding are defined in the shared package dbg_pkg.
REQ-032 The block is a single module with no sub-modules.

Verification
REQ-033 Write path: bytes 77,1B,12,34 with dbg_ready=1 on the second BUS cycle -> exactly 2 cycles of dbg_we with dbg_a=0x1B, dbg_di=0x1234; then tx 0x06.
REQ-034 Read path: bytes 72,41 with dbg_do=0xABCD and dbg_ready after 5 cycles -> tx 0xAB then 0xCD; tx_ready held low for 3 cycles keeps tx_data stable throughout.
REQ-035 Bus timeout: bytes 72,20 with BUS_TIMEOUT=8 and dbg_ready held at 0 -> dbg_rd high for exactly 8 cycles, then tx 0x15.
REQ-036 Dropped byte and junk: byte 0x55 in IDLE -> no activity; a byte sent during BUS -> rx_drop pulse and the frame still completes correctly.
REQ-037 Byte timeout: bytes 77,10 then silence past BYTE_TIMEOUT=100 -> IDLE with no dbg_we; a following 72,10 frame works normally.
REQ-038 Reset mid-operation: rst_n=0 during BUS with dbg_we=1 -> all outputs at reset values after one edge; no tx.
